// File: rtl/axi_uram_arb2_ctrl.sv
// Two-master arbitration and sequencing controller for the single-port axi_uram slave.
// It produces the handshakes and payload mux selects only; the data itself passes through an external datapath.
module axi_uram_arb2_chan #(
  parameter int MAX   = 16,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] m_valid,
  output logic [1:0] m_ready,
  output logic       s_valid,
  input  logic       s_ready,
  output logic       sel,
  input  logic       dec,
  output logic       hs
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state;
  logic             ptr;
  logic             win;
  logic [CNT_W-1:0] cnt;

  assign win     = m_valid[ptr] ? ptr : ~ptr;
  assign s_valid = (state == ST_BUSY);
  assign hs      = s_valid && s_ready;
  assign m_ready = hs ? (sel ? 2'b10 : 2'b01) : 2'b00;

  // sel is captured on grant and held until the slave accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= 1'b0;
      sel   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if ((|m_valid) && (cnt < CNT_W'(MAX))) begin
            sel   <= win;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (s_ready) begin
            state <= ST_IDLE;
            ptr   <= ~sel;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({hs, dec})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module axi_uram_arb2_ctrl #(
  parameter int MAX_OUTSTANDING_TRANX = 16
) (
  input  logic       s_axi_aclk,
  input  logic       s_axi_aresetn,
  input  logic [1:0] m_arvalid,
  output logic [1:0] m_arready,
  output logic       s_arvalid,
  input  logic       s_arready,
  output logic       ar_sel,
  input  logic [1:0] m_awvalid,
  output logic [1:0] m_awready,
  output logic       s_awvalid,
  input  logic       s_awready,
  output logic       aw_sel,
  input  logic [1:0] m_wvalid,
  input  logic [1:0] m_wlast,
  output logic [1:0] m_wready,
  output logic       s_wvalid,
  output logic       s_wlast,
  input  logic       s_wready,
  output logic       w_sel,
  input  logic       s_rvalid,
  input  logic       s_rlast,
  input  logic       s_rid_msb,
  output logic       s_rready,
  output logic [1:0] m_rvalid,
  input  logic [1:0] m_rready,
  input  logic       s_bvalid,
  input  logic       s_bid_msb,
  output logic       s_bready,
  output logic [1:0] m_bvalid,
  input  logic [1:0] m_bready
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING_TRANX + 1);
  localparam int PTR_W = (MAX_OUTSTANDING_TRANX > 1) ? $clog2(MAX_OUTSTANDING_TRANX) : 1;

  logic ar_hs;
  logic aw_hs;
  logic rd_dec;
  logic wr_dec;

  assign rd_dec = s_rvalid && s_rready && s_rlast;
  assign wr_dec = s_bvalid && s_bready;

  axi_uram_arb2_chan #(.MAX(MAX_OUTSTANDING_TRANX), .CNT_W(CNT_W)) u_ar (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .m_valid (m_arvalid),
    .m_ready (m_arready),
    .s_valid (s_arvalid),
    .s_ready (s_arready),
    .sel     (ar_sel),
    .dec     (rd_dec),
    .hs      (ar_hs)
  );

  axi_uram_arb2_chan #(.MAX(MAX_OUTSTANDING_TRANX), .CNT_W(CNT_W)) u_aw (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .m_valid (m_awvalid),
    .m_ready (m_awready),
    .s_valid (s_awvalid),
    .s_ready (s_awready),
    .sel     (aw_sel),
    .dec     (wr_dec),
    .hs      (aw_hs)
  );

  // W order FIFO: one entry per accepted AW; never deeper than wr_cnt, so no full check
  logic             w_mem [MAX_OUTSTANDING_TRANX];
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic [CNT_W-1:0] w_cnt;
  logic             w_empty;
  logic             w_head;
  logic             w_pop;

  assign w_empty = (w_cnt == '0);
  assign w_head  = w_mem[w_rd_ptr];
  assign w_pop   = s_wvalid && s_wready && s_wlast;

  always_ff @(posedge s_axi_aclk) begin
    if (aw_hs) begin
      w_mem[w_wr_ptr] <= aw_sel;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_wr_ptr <= '0;
      w_rd_ptr <= '0;
      w_cnt    <= '0;
    end else begin
      if (aw_hs) begin
        w_wr_ptr <= (w_wr_ptr == PTR_W'(MAX_OUTSTANDING_TRANX - 1)) ? '0 : w_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        w_rd_ptr <= (w_rd_ptr == PTR_W'(MAX_OUTSTANDING_TRANX - 1)) ? '0 : w_rd_ptr + PTR_W'(1);
      end
      case ({aw_hs, w_pop})
        2'b10:   w_cnt <= w_cnt + CNT_W'(1);
        2'b01:   w_cnt <= w_cnt - CNT_W'(1);
        default: w_cnt <= w_cnt;
      endcase
    end
  end

  assign w_sel    = !w_empty && w_head;
  assign s_wvalid = !w_empty && m_wvalid[w_head];
  assign s_wlast  = !w_empty && m_wlast[w_head];
  assign m_wready = (!w_empty && s_wready) ? (w_head ? 2'b10 : 2'b01) : 2'b00;

  // Response routing is combinational, so it is forced quiet while reset is asserted
  assign s_rready = s_axi_aresetn && m_rready[s_rid_msb];
  assign m_rvalid = (s_axi_aresetn && s_rvalid) ? (s_rid_msb ? 2'b10 : 2'b01) : 2'b00;
  assign s_bready = s_axi_aresetn && m_bready[s_bid_msb];
  assign m_bvalid = (s_axi_aresetn && s_bvalid) ? (s_bid_msb ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: tb/tb_axi_uram_arb2_ctrl.sv
// Bench for axi_uram_arb2_ctrl: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_axi_uram_arb2_ctrl;
  localparam int MAX = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] m_arvalid = '0, m_arready;
  logic       s_arvalid, s_arready = 1'b0, ar_sel;
  logic [1:0] m_awvalid = '0, m_awready;
  logic       s_awvalid, s_awready = 1'b0, aw_sel;
  logic [1:0] m_wvalid = '0, m_wlast = '0, m_wready;
  logic       s_wvalid, s_wlast, s_wready = 1'b0, w_sel;
  logic       s_rvalid = 1'b0, s_rlast = 1'b0, s_rid_msb = 1'b0, s_rready;
  logic [1:0] m_rvalid, m_rready = '0;
  logic       s_bvalid = 1'b0, s_bid_msb = 1'b0, s_bready;
  logic [1:0] m_bvalid, m_bready = '0;

  always #5 clk = ~clk;

  axi_uram_arb2_ctrl #(.MAX_OUTSTANDING_TRANX(MAX)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .s_arvalid(s_arvalid), .s_arready(s_arready), .ar_sel(ar_sel),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .s_awvalid(s_awvalid), .s_awready(s_awready), .aw_sel(aw_sel),
    .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready), .s_wvalid(s_wvalid), .s_wlast(s_wlast),
    .s_wready(s_wready), .w_sel(w_sel),
    .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rid_msb(s_rid_msb), .s_rready(s_rready),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_bvalid(s_bvalid), .s_bid_msb(s_bid_msb), .s_bready(s_bready), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: -1 = no grant pending, otherwise the master currently offered to the slave
  int ar_gnt, aw_gnt, ar_pref, aw_pref, rd_out, wr_out;
  int wq[$];

  task automatic model_reset();
    ar_gnt = -1; aw_gnt = -1; ar_pref = 0; aw_pref = 0; rd_out = 0; wr_out = 0;
    wq.delete();
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        int ar_acc, aw_acc, h;
        bit rd_done, wr_done;
        ar_acc = -1; aw_acc = -1;
        rd_done = s_rvalid && m_rready[s_rid_msb] && s_rlast;
        wr_done = s_bvalid && m_bready[s_bid_msb];
        if (ar_gnt >= 0) begin
          if (s_arready) begin ar_acc = ar_gnt; ar_pref = 1 - ar_gnt; ar_gnt = -1; end
        end else if (m_arvalid != 2'b00 && rd_out < MAX) begin
          ar_gnt = m_arvalid[ar_pref] ? ar_pref : 1 - ar_pref;
        end
        if (aw_gnt >= 0) begin
          if (s_awready) begin aw_acc = aw_gnt; aw_pref = 1 - aw_gnt; aw_gnt = -1; end
        end else if (m_awvalid != 2'b00 && wr_out < MAX) begin
          aw_gnt = m_awvalid[aw_pref] ? aw_pref : 1 - aw_pref;
        end
        if (wq.size() > 0) begin
          h = wq[0];
          if (m_wvalid[h] && s_wready && m_wlast[h]) void'(wq.pop_front());
        end
        if (aw_acc >= 0) wq.push_back(aw_acc);
        rd_out = rd_out + (ar_acc >= 0 ? 1 : 0) - (rd_done ? 1 : 0);
        wr_out = wr_out + (aw_acc >= 0 ? 1 : 0) - (wr_done ? 1 : 0);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      begin
        int h;
        chk("s_arvalid", int'(s_arvalid), int'(ar_gnt >= 0));
        if (ar_gnt >= 0) chk("ar_sel", int'(ar_sel), ar_gnt);
        chk("m_arready", int'(m_arready), (ar_gnt >= 0 && s_arready) ? (1 << ar_gnt) : 0);
        chk("s_awvalid", int'(s_awvalid), int'(aw_gnt >= 0));
        if (aw_gnt >= 0) chk("aw_sel", int'(aw_sel), aw_gnt);
        chk("m_awready", int'(m_awready), (aw_gnt >= 0 && s_awready) ? (1 << aw_gnt) : 0);
        if (wq.size() == 0) begin
          chk("s_wvalid(empty)", int'(s_wvalid), 0);
          chk("m_wready(empty)", int'(m_wready), 0);
        end else begin
          h = wq[0];
          chk("w_sel", int'(w_sel), h);
          chk("s_wvalid", int'(s_wvalid), int'(m_wvalid[h]));
          if (m_wvalid[h]) chk("s_wlast", int'(s_wlast), int'(m_wlast[h]));
          chk("m_wready", int'(m_wready), s_wready ? (1 << h) : 0);
        end
        chk("m_rvalid", int'(m_rvalid), (rst_n && s_rvalid) ? (1 << s_rid_msb) : 0);
        chk("s_rready", int'(s_rready), int'(rst_n && m_rready[s_rid_msb]));
        chk("m_bvalid", int'(m_bvalid), (rst_n && s_bvalid) ? (1 << s_bid_msb) : 0);
        chk("s_bready", int'(s_bready), int'(rst_n && m_bready[s_bid_msb]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain_r(input int n);
    for (int i = 0; i < n; i++) begin
      s_rvalid = 1'b1; s_rlast = 1'b1; s_rid_msb = i[0]; m_rready = 2'b11;
      $display("[TB] R beat %0d id_msb=%0d", i, i[0]);
      step(1);
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = 2'b00;
  endtask

  int gq[$];
  int wlog[$];
  int n;
  int wleft[2];
  logic [1:0] hs;
  logic [1:0] awr;
  int exp_w[8] = '{2, 2, 2, 3, 0, 0, 0, 1};

  initial begin
    step(2);
    chk("rst s_arvalid", int'(s_arvalid), 0);
    chk("rst s_awvalid", int'(s_awvalid), 0);
    chk("rst s_wvalid", int'(s_wvalid), 0);
    rst_n = 1'b1;
    step(1);

    // Round-robin with both masters requesting continuously
    m_arvalid = 2'b11; s_arready = 1'b1;
    step(1);
    chk("t1 first s_arvalid", int'(s_arvalid), 1);
    chk("t1 first ar_sel", int'(ar_sel), 0);
    gq.push_back(int'(ar_sel));
    for (int i = 0; i < 7; i++) begin
      step(1);
      if (s_arvalid) gq.push_back(int'(ar_sel));
    end
    chk("t1 grant count", gq.size(), 4);
    for (int i = 0; i < gq.size(); i++) begin
      $display("[TB] AR grant %0d -> master %0d", i, gq[i]);
      chk("t1 grant order", gq[i], i % 2);
    end
    m_arvalid = 2'b00; s_arready = 1'b0;
    step(1);
    drain_r(4);

    // Slave stalls while BUSY; master 1 arrives during the stall
    m_arvalid = 2'b01;
    step(1);
    chk("t2 grant m0", int'(ar_sel), 0);
    m_arvalid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t2 stall s_arvalid", int'(s_arvalid), 1);
      chk("t2 stall ar_sel", int'(ar_sel), 0);
      chk("t2 stall m_arready", int'(m_arready), 0);
    end
    s_arready = 1'b1;
    #1;
    chk("t2 m_arready m0", int'(m_arready), 1);
    step(1);
    chk("t2 idle after hs", int'(s_arvalid), 0);
    step(1);
    chk("t2 next grant valid", int'(s_arvalid), 1);
    chk("t2 next grant m1", int'(ar_sel), 1);
    $display("[TB] AR stall: m0 accepted, then m1 granted");
    m_arvalid = 2'b00;
    step(1);
    s_arready = 1'b0;
    drain_r(2);

    // Outstanding-read limit
    s_arready = 1'b1; m_arvalid = 2'b01; n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (s_arvalid) n++;
    end
    $display("[TB] AR limit: %0d grants with no R", n);
    chk("t3 grants at limit", n, 16);
    chk("t3 blocked", int'(s_arvalid), 0);
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rid_msb = 1'b0; m_rready = 2'b01;
    step(1);
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = 2'b00;
    chk("t3 no grant on release edge", int'(s_arvalid), 0);
    step(1);
    chk("t3 grant after release", int'(s_arvalid), 1);
    step(1);
    m_arvalid = 2'b00; s_arready = 1'b0;
    drain_r(16);

    // W ordering follows AW acceptance order; W offered before its AW is held off
    wleft[0] = 4; wleft[1] = 4;
    m_awvalid = 2'b10; s_awready = 1'b1; s_wready = 1'b1;
    for (int it = 0; it < 24; it++) begin
      m_wvalid = {wleft[1] > 0, wleft[0] > 0};
      m_wlast  = {wleft[1] == 1, wleft[0] == 1};
      @(negedge clk);
      if (it == 0) begin
        chk("t4 W held before AW", int'(s_wvalid), 0);
        chk("t4 m_wready before AW", int'(m_wready), 0);
      end
      if (s_wvalid && s_wready) wlog.push_back(int'(w_sel) * 2 + int'(s_wlast));
      hs = m_wvalid & m_wready;
      awr = m_awready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) if (hs[i]) wleft[i]--;
      if (awr[1]) m_awvalid = 2'b01;
      if (awr[0]) m_awvalid = 2'b00;
    end
    m_wvalid = 2'b00; m_wlast = 2'b00; s_awready = 1'b0;
    chk("t4 W beat count", wlog.size(), 8);
    for (int i = 0; i < wlog.size() && i < 8; i++) begin
      $display("[TB] W beat %0d master=%0d last=%0d", i, wlog[i] / 2, wlog[i] % 2);
      chk("t4 W beat", wlog[i], exp_w[i]);
    end
    s_bvalid = 1'b1; s_bid_msb = 1'b1; m_bready = 2'b11;
    step(1);
    s_bid_msb = 1'b0;
    step(1);
    s_bvalid = 1'b0; m_bready = 2'b00;

    // Response routing by ID MSB
    s_rvalid = 1'b1; s_rlast = 1'b0; s_rid_msb = 1'b1; m_rready = 2'b01;
    #1;
    chk("t5 m_rvalid", int'(m_rvalid), 2);
    chk("t5 s_rready", int'(s_rready), 0);
    s_rvalid = 1'b0; m_rready = 2'b00;
    s_bvalid = 1'b1; s_bid_msb = 1'b1; m_bready = 2'b01;
    #1;
    chk("t5 m_bvalid", int'(m_bvalid), 2);
    chk("t5 s_bready", int'(s_bready), 0);
    $display("[TB] routing id_msb=1 with ready=01: rvalid=%b bvalid=%b", m_rvalid, m_bvalid);
    s_bvalid = 1'b0; m_bready = 2'b00;
    step(1);

    // Asynchronous reset in the middle of an 8-beat write
    m_awvalid = 2'b01; s_awready = 1'b1;
    step(2);
    m_awvalid = 2'b00; s_awready = 1'b0;
    m_wvalid = 2'b01; m_wlast = 2'b00; s_wready = 1'b1;
    step(3);
    #2;
    rst_n = 1'b0;
    s_rvalid = 1'b1; m_rready = 2'b11; s_bvalid = 1'b1; m_bready = 2'b11; m_arvalid = 2'b11;
    #1;
    chk("t6 rst s_wvalid", int'(s_wvalid), 0);
    chk("t6 rst m_wready", int'(m_wready), 0);
    chk("t6 rst s_arvalid", int'(s_arvalid), 0);
    chk("t6 rst s_awvalid", int'(s_awvalid), 0);
    chk("t6 rst s_rready", int'(s_rready), 0);
    chk("t6 rst m_rvalid", int'(m_rvalid), 0);
    chk("t6 rst s_bready", int'(s_bready), 0);
    chk("t6 rst m_bvalid", int'(m_bvalid), 0);
    chk("t6 rst aw_sel", int'(aw_sel), 0);
    $display("[TB] reset asserted mid-write");
    s_rvalid = 1'b0; m_rready = 2'b00; s_bvalid = 1'b0; m_bready = 2'b00;
    step(2);
    rst_n = 1'b1;
    m_awvalid = 2'b11;
    step(1);
    chk("t6 post-rst AR valid", int'(s_arvalid), 1);
    chk("t6 post-rst AR m0", int'(ar_sel), 0);
    chk("t6 post-rst AW m0", int'(aw_sel), 0);
    chk("t6 post-rst FIFO empty", int'(s_wvalid), 0);
    s_arready = 1'b1; s_awready = 1'b1;
    step(1);
    m_arvalid = 2'b00; m_awvalid = 2'b00; m_wvalid = 2'b00;
    s_arready = 1'b0; s_awready = 1'b0;
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
